// File: rtl/cef_wr_if.sv
// Coefficient row stream in from TQ and row write bus out to mode decision.
// master: row producer/write consumer side; slave: the cef_wr block.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

interface cef_wr_if #(
  parameter int COEFF_WIDTH = `COEFF_WIDTH
);
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [COEFF_WIDTH*32-1:0] in_data_i;
  logic                      cef_wen_o;
  logic [4:0]                cef_widx_o;
  logic [COEFF_WIDTH*32-1:0] cef_data_o;

  modport master (
    output in_valid_i,
    output in_data_i,
    input  in_ready_o,
    input  cef_wen_o,
    input  cef_widx_o,
    input  cef_data_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    output in_ready_o,
    output cef_wen_o,
    output cef_widx_o,
    output cef_data_o
  );
endinterface

// File: rtl/cef_wr.sv
// Writes TU coefficient rows into the 32x32 CU coefficient store.
// Ports: clk, rst_n (sync, active-high), start_i/tu_size_i/tu_y_i,
// bus (rows in, writes out), nz_o, done_o, err_o.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module cef_wr #(
  parameter int COEFF_WIDTH = `COEFF_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [1:0] tu_size_i,
  input  logic [2:0] tu_y_i,
  cef_wr_if.slave    bus,
  output logic       nz_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int DW = COEFF_WIDTH * 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      size_q, size_d;
  logic [4:0]      base_q, base_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            nz_q, nz_d;
  logic            wen_q, wen_d;
  logic [4:0]      widx_q, widx_d;
  logic [DW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [5:0]      n_start;
  logic [5:0]      n_cur;
  logic [6:0]      end_row;
  logic            fit;
  logic            accept;
  logic [DW-1:0]   masked;
  logic            row_nz;

  assign n_start = 6'd4 << tu_size_i;
  assign n_cur   = 6'd4 << size_q;
  assign end_row = {2'b00, tu_y_i, 2'b00}
                 + {1'b0, n_start};
  assign fit     = end_row <= 7'd32;
  assign accept  = (state_q == RUN)
                 & bus.in_valid_i;

  // Lanes beyond the TU width are zeroed and
  // excluded from the nonzero flag.
  always_comb begin
    masked = '0;
    row_nz = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (6'(i) < n_cur) begin
        masked[i*COEFF_WIDTH +: COEFF_WIDTH] =
          bus.in_data_i[i*COEFF_WIDTH +: COEFF_WIDTH];
        if (|bus.in_data_i[i*COEFF_WIDTH +: COEFF_WIDTH])
          row_nz = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    nz_d    = nz_q;
    wen_d   = 1'b0;
    widx_d  = widx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (fit) begin
            state_d = RUN;
            size_d  = tu_size_i;
            base_d  = {tu_y_i, 2'b00};
            cnt_d   = '0;
            nz_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          wen_d  = 1'b1;
          widx_d = base_q + cnt_q;
          data_d = masked;
          nz_d   = nz_q | row_nz;
          cnt_d  = cnt_q + 5'd1;
          if ({1'b0, cnt_q} == n_cur - 6'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      size_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      nz_q    <= 1'b0;
      wen_q   <= 1'b0;
      widx_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      nz_q    <= nz_d;
      wen_q   <= wen_d;
      widx_q  <= widx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready_o = (state_q == RUN);
  assign bus.cef_wen_o  = wen_q;
  assign bus.cef_widx_o = widx_q;
  assign bus.cef_data_o = data_q;
  assign nz_o           = nz_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_cef_wr.sv
// Directed + randomized bench for cef_wr against a
// TU-level reference model.
module tb_cef_wr;

  localparam int W  = 16;
  localparam int DW = W * 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] tu_size = '0;
  logic [2:0] tu_y = '0;
  logic       nz, done, err;

  int n_pass = 0;
  int n_chk  = 0;

  cef_wr_if #(.COEFF_WIDTH(W)) bus ();

  cef_wr #(.COEFF_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst),
    .start_i   (start),
    .tu_size_i (tu_size),
    .tu_y_i    (tu_y),
    .bus       (bus),
    .nz_o      (nz),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 receiving rows, 2 done cycle
  int            phase;
  int            m_n, m_base, m_row;
  bit            m_nz;
  bit            e_wen, e_done, e_err, chk_nz;
  logic [4:0]    e_widx;
  logic [DW-1:0] e_data;

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%b exp=%b",
                tag, obs, exp);
  endtask

  task automatic chkw(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%h exp=%h",
                tag, obs, exp);
  endtask

  task automatic step();
    bit acc;
    chk1("in_ready", bus.in_ready_o, phase == 1);
    acc    = (phase == 1) && bus.in_valid_i;
    e_wen  = 0;
    e_done = 0;
    e_err  = 0;
    chk_nz = 0;
    if (rst) begin
      phase  = 0;
      m_row  = 0;
      m_nz   = 0;
      e_widx = '0;
      e_data = '0;
      chk_nz = 1;
    end else if (phase == 0) begin
      if (start) begin
        int n;
        n = 4 << int'(tu_size);
        if (int'(tu_y) * 4 + n <= 32) begin
          phase  = 1;
          m_n    = n;
          m_base = int'(tu_y) * 4;
          m_row  = 0;
          m_nz   = 0;
        end else begin
          e_err = 1;
        end
      end
    end else if (phase == 1) begin
      if (acc) begin
        e_wen  = 1;
        e_widx = 5'((m_base + m_row) % 32);
        e_data = '0;
        for (int i = 0; i < m_n; i++) begin
          e_data[i*W +: W] = bus.in_data_i[i*W +: W];
          if (bus.in_data_i[i*W +: W] != 0) m_nz = 1;
        end
        m_row++;
        if (m_row == m_n) begin
          phase  = 2;
          e_done = 1;
          chk_nz = 1;
        end
      end
    end else begin
      phase = 0;
    end
    @(posedge clk);
    #1;
    chk1("cef_wen", bus.cef_wen_o, e_wen);
    chkw("cef_widx", DW'(bus.cef_widx_o), DW'(e_widx));
    chkw("cef_data", bus.cef_data_o, e_data);
    chk1("done", done, e_done);
    chk1("err", err, e_err);
    if (chk_nz) chk1("nz", nz, m_nz);
  endtask

  // kind 0: zeros, 1: sparse random, 2: 1s in lanes 0..3, 7 in lane 31
  task automatic set_row(input int kind);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 32; i++) begin
      if (kind == 1 && $urandom_range(0, 3) == 0)
        d[i*W +: W] = W'($urandom);
      if (kind == 2 && i < 4) d[i*W +: W] = W'(1);
      if (kind == 2 && i == 31) d[i*W +: W] = W'(7);
    end
    bus.in_data_i = d;
  endtask

  // vmode 0: valid held, 1: toggling, 2: random
  task automatic run_tu(input int size, input int y,
                        input int kind, input int vmode,
                        input bit spur);
    int  guard;
    bit  tg;
    start   = 1;
    tu_size = 2'(size);
    tu_y    = 3'(y);
    bus.in_valid_i = 0;
    step();
    start = 0;
    guard = 0;
    tg    = 1;
    while (phase != 0 && guard < 400) begin
      case (vmode)
        0:       bus.in_valid_i = 1;
        1:       bus.in_valid_i = tg;
        default: bus.in_valid_i = 1'($urandom_range(0, 1));
      endcase
      tg = !tg;
      set_row(kind);
      start = spur && ($urandom_range(0, 3) == 0);
      if (start) begin
        tu_size = 2'($urandom);
        tu_y    = 3'($urandom);
      end
      step();
      guard++;
    end
    start = 0;
    bus.in_valid_i = 0;
    chk1("tu_timeout", guard < 400, 1'b1);
  endtask

  initial begin
    bus.in_valid_i = 0;
    bus.in_data_i  = '0;
    rst = 1;
    @(posedge clk);
    #1;
    phase  = 0;
    m_nz   = 0;
    e_widx = '0;
    e_data = '0;
    step();
    step();
    rst = 0;

    // 4x4 at row 8, lane 31 must be dropped
    run_tu(0, 2, 2, 0, 0);

    // 32x32 zeros with valid gaps
    run_tu(3, 0, 0, 1, 0);

    // 16x16 overflowing the CU, then a legal one
    run_tu(2, 5, 1, 0, 0);
    step();
    run_tu(2, 4, 1, 2, 0);

    // reset mid-TU after three rows
    start   = 1;
    tu_size = 2'd1;
    tu_y    = 3'd0;
    step();
    start = 0;
    bus.in_valid_i = 1;
    while (phase == 1 && m_row < 3) begin
      set_row(1);
      step();
    end
    rst = 1;
    set_row(1);
    step();
    rst = 0;
    bus.in_valid_i = 0;
    run_tu(1, 0, 1, 0, 0);

    // rows offered in idle, starts during run
    bus.in_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      set_row(1);
      step();
    end
    bus.in_valid_i = 0;
    run_tu(1, 3, 1, 2, 1);

    // random back-to-back TUs
    for (int t = 0; t < 30; t++) begin
      run_tu($urandom_range(0, 3), $urandom_range(0, 7),
             $urandom_range(0, 2) == 0 ? 0 : 1,
             $urandom_range(0, 2), 1);
      if ($urandom_range(0, 1) == 0) step();
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
